// File: rtl/count_rr_sched.sv
// Round-robin scheduler sharing one up-counter between NREQ requesters.
// Each job counts 0..len-1 under a one-hot grant and ends with a one-cycle done pulse.
module count_rr_sched #(
    parameter int NREQ = 4,
    parameter int CW   = 7
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NREQ-1:0]    i_req,
    input  logic [NREQ*CW-1:0] i_len,
    input  logic               i_abort,
    output logic [NREQ-1:0]    o_gnt,
    output logic [CW-1:0]      o_cnt,
    output logic [NREQ-1:0]    o_done,
    output logic               o_busy
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   owner;
    logic [IW-1:0]   owner_next;
    logic [IW-1:0]   win;
    logic [IW-1:0]   idx;
    logic            found;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   len_q;
    logic [CW-1:0]   win_len;
    logic [NREQ-1:0] win_oh;
    logic [NREQ-1:0] owner_oh;

    // Search starts at ptr and wraps, so the last owner is visited last.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = IW'((int'(ptr) + k) % NREQ);
            if (!found && i_req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    assign win_len    = i_len[win*CW +: CW];
    assign win_oh     = NREQ'(1) << win;
    assign owner_oh   = NREQ'(1) << owner;
    assign owner_next = (owner == IW'(NREQ - 1)) ? '0 : owner + IW'(1);
    assign o_cnt      = cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            ptr    <= '0;
            owner  <= '0;
            len_q  <= '0;
            cnt    <= '0;
            o_gnt  <= '0;
            o_done <= '0;
            o_busy <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        owner  <= win;
                        len_q  <= win_len;
                        cnt    <= '0;
                        o_busy <= 1'b1;
                        if (win_len != '0) begin
                            state <= RUN;
                            o_gnt <= win_oh;
                        end else begin
                            state  <= DONE;
                            o_done <= win_oh;
                        end
                    end
                end
                RUN: begin
                    // Abort outranks the terminal count and suppresses the done pulse.
                    if (i_abort) begin
                        state  <= IDLE;
                        cnt    <= '0;
                        ptr    <= owner_next;
                        o_gnt  <= '0;
                        o_busy <= 1'b0;
                    end else if (cnt == len_q - CW'(1)) begin
                        state  <= DONE;
                        o_gnt  <= '0;
                        o_done <= owner_oh;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    cnt    <= '0;
                    ptr    <= owner_next;
                    o_done <= '0;
                    o_busy <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    cnt    <= '0;
                    o_gnt  <= '0;
                    o_done <= '0;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_count_rr_sched.sv
// Directed bench for count_rr_sched: a per-cycle vector table plus
// hand-written sequences for fairness, zero/max length, abort and async reset.
module tb_count_rr_sched;

    localparam int NREQ = 4;
    localparam int CW   = 7;

    logic               clk = 1'b0;
    logic               reset_n;
    logic [NREQ-1:0]    i_req;
    logic [NREQ*CW-1:0] i_len;
    logic               i_abort;
    logic [NREQ-1:0]    o_gnt;
    logic [CW-1:0]      o_cnt;
    logic [NREQ-1:0]    o_done;
    logic               o_busy;

    int checks = 0;
    int errors = 0;

    count_rr_sched #(.NREQ(NREQ), .CW(CW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .i_req   (i_req),
        .i_len   (i_len),
        .i_abort (i_abort),
        .o_gnt   (o_gnt),
        .o_cnt   (o_cnt),
        .o_done  (o_done),
        .o_busy  (o_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NREQ-1:0]    req;
        logic [NREQ*CW-1:0] len;
        logic               abort;
        logic [NREQ-1:0]    gnt;
        logic [CW-1:0]      cnt;
        logic [NREQ-1:0]    done;
        logic               busy;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [NREQ*CW-1:0] lens(input int a, input int b, input int c, input int d);
        return {CW'(d), CW'(c), CW'(b), CW'(a)};
    endfunction

    task automatic add(input logic [NREQ-1:0] req, input logic [NREQ*CW-1:0] len, input logic abort,
                       input logic [NREQ-1:0] gnt, input int cnt, input logic [NREQ-1:0] done,
                       input logic busy);
        vec_t v;
        v.req = req; v.len = len; v.abort = abort;
        v.gnt = gnt; v.cnt = CW'(cnt); v.done = done; v.busy = busy;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        i_req   = '0;
        i_len   = '0;
        i_abort = 1'b0;
        #13;
        reset_n = 1'b1;
    endtask

    initial begin
        int n;
        int g;
        logic [CW-1:0] last;
        logic bad;
        logic [NREQ-1:0] exp_oh;
        int order[4] = '{0, 2, 0, 2};

        // Reset state
        reset_n = 1'b0;
        i_req   = '0;
        i_len   = '0;
        i_abort = 1'b0;
        #3;
        chk("rst_gnt", 32'(o_gnt), 0);
        chk("rst_cnt", 32'(o_cnt), 0);
        chk("rst_done", 32'(o_done), 0);
        chk("rst_busy", 32'(o_busy), 0);
        #10;
        reset_n = 1'b1;

        // Simultaneous requests, len=3 each: order 0,1,2,3 with 2-cycle gaps
        for (int r = 0; r < NREQ; r++) begin
            logic [NREQ-1:0] pend;
            logic [NREQ-1:0] oh;
            pend = 4'b1111 << r;
            oh   = 4'b0001 << r;
            if (r > 0) add(pend, lens(3,3,3,3), 1'b0, 4'b0000, 0, 4'b0000, 1'b0);
            for (int c = 0; c < 3; c++) add(pend, lens(3,3,3,3), 1'b0, oh, c, 4'b0000, 1'b1);
            add(pend, lens(3,3,3,3), 1'b0, 4'b0000, 2, oh, 1'b1);
        end
        add(4'b0000, lens(3,3,3,3), 1'b0, 4'b0000, 0, 4'b0000, 1'b0);
        // ptr back at 0: requester 0 beats 1; abort it, then 1 is served next
        add(4'b0011, lens(3,3,3,3), 1'b0, 4'b0001, 0, 4'b0000, 1'b1);
        add(4'b0000, lens(3,3,3,3), 1'b1, 4'b0000, 0, 4'b0000, 1'b0);
        add(4'b0011, lens(3,3,3,3), 1'b0, 4'b0010, 0, 4'b0000, 1'b1);
        add(4'b0000, lens(3,3,3,3), 1'b1, 4'b0000, 0, 4'b0000, 1'b0);
        // Single job on requester 1, len=5; later i_len changes must be ignored
        add(4'b0010, lens(5,5,5,5), 1'b0, 4'b0010, 0, 4'b0000, 1'b1);
        for (int c = 1; c < 5; c++) add(4'b0010, lens(1,1,1,1), 1'b0, 4'b0010, c, 4'b0000, 1'b1);
        add(4'b0010, lens(1,1,1,1), 1'b0, 4'b0000, 4, 4'b0010, 1'b1);
        add(4'b0000, lens(1,1,1,1), 1'b0, 4'b0000, 0, 4'b0000, 1'b0);

        foreach (tbl[i]) begin
            i_req   = tbl[i].req;
            i_len   = tbl[i].len;
            i_abort = tbl[i].abort;
            step();
            chk($sformatf("tbl%0d_gnt", i), 32'(o_gnt), 32'(tbl[i].gnt));
            chk($sformatf("tbl%0d_cnt", i), 32'(o_cnt), 32'(tbl[i].cnt));
            chk($sformatf("tbl%0d_done", i), 32'(o_done), 32'(tbl[i].done));
            chk($sformatf("tbl%0d_busy", i), 32'(o_busy), 32'(tbl[i].busy));
        end
        i_abort = 1'b0;

        // Fairness: 0 and 2 both held continuously -> 0,2,0,2
        do_reset();
        i_req = 4'b0101;
        i_len = lens(2,2,2,2);
        for (int j = 0; j < 4; j++) begin
            exp_oh = 4'b0001 << order[j];
            n = 0;
            while (o_gnt == '0 && n < 10) begin step(); n++; end
            chk($sformatf("fair%0d_gnt", j), 32'(o_gnt), 32'(exp_oh));
            n = 0;
            while (o_done == '0 && n < 10) begin step(); n++; end
            chk($sformatf("fair%0d_done", j), 32'(o_done), 32'(exp_oh));
        end
        i_req = '0;
        step();
        step();

        // Zero length: done one cycle after sampling, no grant
        do_reset();
        i_req = 4'b0001;
        i_len = lens(0,0,0,0);
        step();
        chk("zero_done", 32'(o_done), 32'h1);
        chk("zero_gnt", 32'(o_gnt), 0);
        chk("zero_busy", 32'(o_busy), 1);
        chk("zero_cnt", 32'(o_cnt), 0);
        i_req = '0;
        step();
        chk("zero_idle_busy", 32'(o_busy), 0);
        chk("zero_idle_done", 32'(o_done), 0);

        // Maximum length 127: 127 grant cycles, counter stops at 126
        do_reset();
        i_req = 4'b0100;
        i_len = lens(0,0,127,0);
        step();
        g = 0;
        bad = 1'b0;
        last = '0;
        while (o_gnt == 4'b0100 && g < 200) begin
            if (o_cnt != CW'(g)) bad = 1'b1;
            last = o_cnt;
            g++;
            step();
        end
        chk("max_gnt_cycles", 32'(g), 127);
        chk("max_seq", 32'(bad), 0);
        chk("max_last_cnt", 32'(last), 126);
        chk("max_done", 32'(o_done), 32'h4);
        chk("max_done_cnt", 32'(o_cnt), 126);
        i_req = '0;
        step();
        chk("max_idle_cnt", 32'(o_cnt), 0);

        // Abort at cnt=4 of a len=10 job; owner+1 is served next
        do_reset();
        i_req = 4'b0011;
        i_len = lens(10,3,0,0);
        step();
        chk("abort_gnt0", 32'(o_gnt), 32'h1);
        repeat (4) step();
        chk("abort_cnt4", 32'(o_cnt), 4);
        i_abort = 1'b1;
        step();
        i_abort = 1'b0;
        chk("abort_gnt", 32'(o_gnt), 0);
        chk("abort_busy", 32'(o_busy), 0);
        chk("abort_done", 32'(o_done), 0);
        chk("abort_cnt", 32'(o_cnt), 0);
        step();
        chk("abort_next_gnt", 32'(o_gnt), 32'h2);
        chk("abort_next_done", 32'(o_done), 0);
        i_req = '0;
        i_abort = 1'b1;
        step();
        i_abort = 1'b0;

        // Async reset between edges at cnt=6
        do_reset();
        i_req = 4'b0001;
        i_len = lens(10,0,0,0);
        step();
        repeat (6) step();
        chk("arst_pre_cnt", 32'(o_cnt), 6);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_gnt", 32'(o_gnt), 0);
        chk("arst_cnt", 32'(o_cnt), 0);
        chk("arst_done", 32'(o_done), 0);
        chk("arst_busy", 32'(o_busy), 0);
        i_req = 4'b0100;
        i_len = lens(0,0,4,0);
        #10;
        reset_n = 1'b1;
        step();
        chk("arst_regrant", 32'(o_gnt), 32'h4);
        chk("arst_regrant_cnt", 32'(o_cnt), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
